interfaz_memoria: RTL and testbench
===================================

// Module: interfaz_memoria
// PURPOSE
//  Bus-side memory access sequencer between the CISC datapath (MAR/MDR) and external memory.
//  Downstream of the control unit: accepts one read or write request at a time.
//  Drives the external strobes, waits for the memory acknowledge, and returns read data.
//  Raises a completion or timeout indication, so the control FSM can advance past fetch/load/store states.
// PARAMETERS
//  ANCHO_DATOS    16  data bus width (bits)
//  ANCHO_DIR      16  address bus width (bits)
//  LIMITE_ESPERA  15  max cycles in ACCESO without MemListo before timeout (>=1)
//  ANCHO_CONT      4  wait-counter width; must satisfy 2**ANCHO_CONT > LIMITE_ESPERA
// PORTS
//  Reloj          in   1            single clock, rising edge
//  Reiniciar      in   1            asynchronous, active-low reset
//  Solicitud      in   1            request strobe from control unit; sampled only in REPOSO
//  Escribir       in   1            1=write, 0=read; sampled with Solicitud
//  Direccion      in   ANCHO_DIR    access address (from MAR)
//  DatoEscritura  in   ANCHO_DATOS  write data (from MDR)
//  DatoLectura    out  ANCHO_DATOS  last successfully read word (to MDR/IR)
//  Listo          out  1            1-cycle pulse: access finished (ok or timeout)
//  Error          out  1            1-cycle pulse with Listo when the access timed out
//  Ocupado        out  1            1 in every state except REPOSO
//  MemDir         out  ANCHO_DIR    address to memory
//  MemDatoSal     out  ANCHO_DATOS  write data to memory
//  MemLeer        out  1            read strobe
//  MemEscribir    out  1            write strobe
//  MemDatoEnt     in   ANCHO_DATOS  read data from memory; valid when MemListo=1
//  MemListo       in   1            memory acknowledge
// BEHAVIOUR
//  - All outputs are registered, except Ocupado, which is decoded from state.
//  - Reset (Reiniciar=0, async) forces the following immediately, including mid-access:
//      state=REPOSO; counter=0; DatoLectura=0; Listo=0; Error=0;
//      MemDir=0; MemDatoSal=0; MemLeer=0; MemEscribir=0.
//  - FSM states: REPOSO, ACCESO, ENTREGA, FALLO.
//  - REPOSO:
//      Solicitud=1 at edge: capture Direccion->MemDir. Set MemLeer=~Escribir and MemEscribir=Escribir.
//      On a write, capture DatoEscritura->MemDatoSal. Clear the counter. Go to ACCESO.
//      MemListo in REPOSO is ignored.
//  - ACCESO: exactly one strobe high; MemDir/MemDatoSal stable for the whole state.
//      MemListo=1 at edge: clear strobes and MemDatoSal. On a read, latch MemDatoEnt->DatoLectura.
//        Then Listo<=1, Error<=0, go to ENTREGA.
//      Else if counter==LIMITE_ESPERA-1: clear strobes, Listo<=1, Error<=1, go to FALLO.
//        DatoLectura is unchanged.
//      Else counter+1 (saturating; it never wraps).
//      MemListo and the timeout in the same cycle: MemListo wins (success).
//  - ENTREGA / FALLO:
//      Listo (and Error in FALLO) is high for exactly this one cycle. Both clear on exit.
//      Next state is always REPOSO.
//      Solicitud here is ignored; the requester re-issues after Ocupado falls.
//  - Latency: Solicitud at edge N; strobe high in cycle N+1.
//      With MemListo=1 in cycle N+1, Listo=1 in cycle N+2 (2-cycle minimum).
//      With no ack, Listo/Error occur in cycle N+1+LIMITE_ESPERA.
//  - Back-to-back: the earliest next acceptance is the edge that ends the ENTREGA/FALLO cycle.
//  - Writes never modify DatoLectura.
// STRUCTURE
//  - interfaz_memoria_defs.vh (shared include):
//      2-bit state encodings (REPOSO=2'd0, ACCESO=2'd1, ENTREGA=2'd2, FALLO=2'd3);
//      default widths; LIMITE_ESPERA default.
//      The control unit includes the same file for its handshake expectations.
//  - One sub-module: contador_espera.
//      Ports: Reloj, Reiniciar, Limpiar, Habilitar, Agotado.
//      Parameterised by LIMITE_ESPERA and ANCHO_CONT.
//  - The FSM and the datapath registers stay in interfaz_memoria.
// TESTING
//  1. Reset mid-ACCESO (read to 16'h0040 in flight), Reiniciar=0 asynchronously:
//       MemLeer=0, Ocupado=0, DatoLectura=0 with no clock edge.
//       After release, a fresh read completes normally.
//  2. Read 16'h0010; memory acks 2 cycles later with 16'hBEEF:
//       MemLeer=1 for 3 cycles; DatoLectura=16'hBEEF; Listo=1, Error=0 for one cycle.
//  3. Write 16'h1234 to 16'h00FF, zero-wait ack:
//       MemEscribir=1 for 1 cycle with MemDir=16'h00FF and MemDatoSal=16'h1234.
//       Listo follows on the next cycle. DatoLectura is unchanged.
//  4. Read with MemListo held 0 (LIMITE_ESPERA=15):
//       MemLeer high for exactly 15 cycles, then Listo=1 and Error=1 for one cycle.
//       State returns to REPOSO.
//  5. MemListo rises on the 15th ACCESO cycle (the timeout cycle):
//       Success: Error=0, DatoLectura is updated.
//  6. Solicitud held high continuously, with alternating read/write:
//       One access per REPOSO visit. Requests during ACCESO/ENTREGA are ignored.
//       No strobe is ever asserted in ENTREGA.

Source files
------------

// File: rtl/interfaz_memoria_pkg.sv
// -----------------------------------------------------------------------------
// interfaz_memoria_pkg
//   Shared definitions for the memory access sequencer and its users (the
//   control unit relies on the same state encoding for its handshake view).
//   - estado_t : 2-bit FSM state encoding
//   - default data/address widths, wait limit and wait-counter width
// -----------------------------------------------------------------------------
package interfaz_memoria_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        ACCESO  = 2'd1,
        ENTREGA = 2'd2,
        FALLO   = 2'd3
    } estado_t;

    localparam int ANCHO_DATOS_DEF   = 16;
    localparam int ANCHO_DIR_DEF     = 16;
    localparam int LIMITE_ESPERA_DEF = 15;
    localparam int ANCHO_CONT_DEF    = 4;

endpackage

// File: rtl/interfaz_memoria_contador_espera.sv
// -----------------------------------------------------------------------------
// contador_espera
//   Counts cycles spent waiting for the memory acknowledge.
//   Ports:
//     Reloj     in  clock, rising edge
//     Reiniciar in  asynchronous active-low reset (count -> 0)
//     Limpiar   in  synchronous clear (start of a new access)
//     Habilitar in  advance the count by one this cycle
//     Agotado   out count has reached LIMITE_ESPERA-1 (last allowed wait cycle)
//   The count saturates at LIMITE_ESPERA-1 so it can never wrap.
// -----------------------------------------------------------------------------
module contador_espera #(
    parameter int LIMITE_ESPERA = 15,
    parameter int ANCHO_CONT    = 4
) (
    input  logic Reloj,
    input  logic Reiniciar,
    input  logic Limpiar,
    input  logic Habilitar,
    output logic Agotado
);

    localparam logic [ANCHO_CONT-1:0] ULTIMO = ANCHO_CONT'(LIMITE_ESPERA - 1);

    logic [ANCHO_CONT-1:0] cuenta;

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            cuenta <= '0;
        end else if (Limpiar) begin
            cuenta <= '0;
        end else if (Habilitar && (cuenta != ULTIMO)) begin
            cuenta <= cuenta + ANCHO_CONT'(1);
        end
    end

    assign Agotado = (cuenta == ULTIMO);

endmodule

// File: rtl/interfaz_memoria.sv
// -----------------------------------------------------------------------------
// interfaz_memoria
//   Bus-side memory access sequencer between the datapath (MAR/MDR) and the
//   external memory. Accepts one read or write at a time, drives the strobes,
//   waits for MemListo (bounded by LIMITE_ESPERA cycles) and reports the end of
//   the access with a one-cycle Listo pulse (plus Error on timeout).
//   Ports:
//     Reloj, Reiniciar            clock / async active-low reset
//     Solicitud, Escribir         request strobe and direction (sampled in REPOSO)
//     Direccion, DatoEscritura    address and write data from MAR/MDR
//     DatoLectura                 last successfully read word
//     Listo, Error                completion / timeout pulses (registered)
//     Ocupado                     1 whenever the FSM is not in REPOSO (decoded)
//     MemDir, MemDatoSal          address / write data to memory (registered)
//     MemLeer, MemEscribir        memory strobes (registered)
//     MemDatoEnt, MemListo        read data and acknowledge from memory
//   Handshake: a request is taken on the rising edge where Solicitud=1 and the
//   FSM is in REPOSO; anything on Solicitud while Ocupado=1 is dropped, so the
//   requester holds or re-issues its request until Ocupado falls.
// -----------------------------------------------------------------------------
module interfaz_memoria
    import interfaz_memoria_pkg::*;
#(
    parameter int ANCHO_DATOS   = ANCHO_DATOS_DEF,
    parameter int ANCHO_DIR     = ANCHO_DIR_DEF,
    parameter int LIMITE_ESPERA = LIMITE_ESPERA_DEF,
    parameter int ANCHO_CONT    = ANCHO_CONT_DEF
) (
    input  logic                   Reloj,
    input  logic                   Reiniciar,
    input  logic                   Solicitud,
    input  logic                   Escribir,
    input  logic [ANCHO_DIR-1:0]   Direccion,
    input  logic [ANCHO_DATOS-1:0] DatoEscritura,
    output logic [ANCHO_DATOS-1:0] DatoLectura,
    output logic                   Listo,
    output logic                   Error,
    output logic                   Ocupado,
    output logic [ANCHO_DIR-1:0]   MemDir,
    output logic [ANCHO_DATOS-1:0] MemDatoSal,
    output logic                   MemLeer,
    output logic                   MemEscribir,
    input  logic [ANCHO_DATOS-1:0] MemDatoEnt,
    input  logic                   MemListo
);

    // Current FSM state; kept as a named signal so checkers can bind to it.
    estado_t estado;

    logic limpiar;
    logic habilitar;
    logic agotado;

    // A new access always starts its wait count from zero.
    assign limpiar   = (estado == REPOSO) && Solicitud;
    // Only cycles that end without an acknowledge count as waiting.
    assign habilitar = (estado == ACCESO) && !MemListo;

    contador_espera #(
        .LIMITE_ESPERA (LIMITE_ESPERA),
        .ANCHO_CONT    (ANCHO_CONT)
    ) u_contador (
        .Reloj     (Reloj),
        .Reiniciar (Reiniciar),
        .Limpiar   (limpiar),
        .Habilitar (habilitar),
        .Agotado   (agotado)
    );

    assign Ocupado = (estado != REPOSO);

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            estado      <= REPOSO;
            DatoLectura <= '0;
            Listo       <= 1'b0;
            Error       <= 1'b0;
            MemDir      <= '0;
            MemDatoSal  <= '0;
            MemLeer     <= 1'b0;
            MemEscribir <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (Solicitud) begin
                        MemDir      <= Direccion;
                        MemLeer     <= ~Escribir;
                        MemEscribir <= Escribir;
                        if (Escribir) begin
                            MemDatoSal <= DatoEscritura;
                        end
                        estado <= ACCESO;
                    end
                end

                ACCESO: begin
                    // The acknowledge is checked first so that an ack arriving
                    // in the last allowed cycle still counts as a success.
                    if (MemListo) begin
                        MemLeer     <= 1'b0;
                        MemEscribir <= 1'b0;
                        MemDatoSal  <= '0;
                        if (MemLeer) begin
                            DatoLectura <= MemDatoEnt;
                        end
                        Listo  <= 1'b1;
                        Error  <= 1'b0;
                        estado <= ENTREGA;
                    end else if (agotado) begin
                        MemLeer     <= 1'b0;
                        MemEscribir <= 1'b0;
                        Listo       <= 1'b1;
                        Error       <= 1'b1;
                        estado      <= FALLO;
                    end
                end

                ENTREGA, FALLO: begin
                    Listo  <= 1'b0;
                    Error  <= 1'b0;
                    estado <= REPOSO;
                end

                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interfaz_memoria.sv
// -----------------------------------------------------------------------------
// tb_interfaz_memoria
//   Transaction-level model of the sequencer, a memory responder with a
//   configurable acknowledge delay, directed scenarios and a random phase.
// -----------------------------------------------------------------------------
module tb_interfaz_memoria;

    localparam int LIM = 15;

    // ---------------- clock / reset ----------------
    logic        Reloj = 1'b0;
    logic        Reiniciar = 1'b0;
    logic        Solicitud = 1'b0;
    logic        Escribir = 1'b0;
    logic [15:0] Direccion = '0;
    logic [15:0] DatoEscritura = '0;
    logic [15:0] MemDatoEnt = '0;
    logic        MemListo = 1'b0;

    logic [15:0] DatoLectura;
    logic        Listo;
    logic        Error;
    logic        Ocupado;
    logic [15:0] MemDir;
    logic [15:0] MemDatoSal;
    logic        MemLeer;
    logic        MemEscribir;

    always #5 Reloj = ~Reloj;

    interfaz_memoria #(
        .ANCHO_DATOS   (16),
        .ANCHO_DIR     (16),
        .LIMITE_ESPERA (LIM),
        .ANCHO_CONT    (4)
    ) dut (
        .Reloj         (Reloj),
        .Reiniciar     (Reiniciar),
        .Solicitud     (Solicitud),
        .Escribir      (Escribir),
        .Direccion     (Direccion),
        .DatoEscritura (DatoEscritura),
        .DatoLectura   (DatoLectura),
        .Listo         (Listo),
        .Error         (Error),
        .Ocupado       (Ocupado),
        .MemDir        (MemDir),
        .MemDatoSal    (MemDatoSal),
        .MemLeer       (MemLeer),
        .MemEscribir   (MemEscribir),
        .MemDatoEnt    (MemDatoEnt),
        .MemListo      (MemListo)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An access is "open" from acceptance until it either sees MemListo or has
    // waited LIM cycles; the cycle after that is the completion pulse.
    logic [15:0] m_dato = '0, m_dir = '0, m_dsal = '0;
    logic        m_listo = 1'b0, m_error = 1'b0, m_leer = 1'b0, m_escr = 1'b0;
    bit          m_abierto = 1'b0, m_fin = 1'b0, m_wr = 1'b0;
    int          m_esperado = 0;

    always @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            m_dato = '0; m_dir = '0; m_dsal = '0;
            m_listo = 1'b0; m_error = 1'b0; m_leer = 1'b0; m_escr = 1'b0;
            m_abierto = 1'b0; m_fin = 1'b0; m_esperado = 0;
        end else if (m_fin) begin
            m_fin = 1'b0; m_listo = 1'b0; m_error = 1'b0;
        end else if (m_abierto) begin
            m_esperado++;
            if (MemListo) begin
                if (!m_wr) m_dato = MemDatoEnt;
                m_leer = 1'b0; m_escr = 1'b0; m_dsal = '0;
                m_listo = 1'b1; m_error = 1'b0;
                m_abierto = 1'b0; m_fin = 1'b1;
            end else if (m_esperado == LIM) begin
                m_leer = 1'b0; m_escr = 1'b0;
                m_listo = 1'b1; m_error = 1'b1;
                m_abierto = 1'b0; m_fin = 1'b1;
            end
        end else if (Solicitud) begin
            m_wr = Escribir;
            m_dir = Direccion;
            if (Escribir) m_dsal = DatoEscritura;
            m_leer = !Escribir; m_escr = Escribir;
            m_abierto = 1'b1; m_esperado = 0;
        end
    end

    // ---------------- compare process (every cycle) ----------------
    int          n_leer = 0, n_escr = 0, n_listo = 0, n_error = 0;
    logic [15:0] esc_dir = '0, esc_dat = '0;

    always @(negedge Reloj) begin
        chk("DatoLectura", DatoLectura, m_dato);
        chk("Listo", Listo, m_listo);
        chk("Error", Error, m_error);
        chk("Ocupado", Ocupado, m_abierto | m_fin);
        chk("MemDir", MemDir, m_dir);
        chk("MemDatoSal", MemDatoSal, m_dsal);
        chk("MemLeer", MemLeer, m_leer);
        chk("MemEscribir", MemEscribir, m_escr);
        chk("una_sola_senal", MemLeer & MemEscribir, 1'b0);
        if (MemLeer) n_leer++;
        if (MemEscribir) begin
            n_escr++;
            esc_dir = MemDir;
            esc_dat = MemDatoSal;
        end
        if (Listo) n_listo++;
        if (Error) n_error++;
    end

    // ---------------- memory responder ----------------
    int          ack_after = 0;
    logic [15:0] ack_data = '0;
    bit          rand_mode = 1'b0;
    int          strobe_cnt = 0;

    always @(negedge Reloj) begin
        if (MemLeer || MemEscribir) begin
            if (strobe_cnt == 0 && rand_mode) begin
                ack_after = int'($urandom_range(0, 18));
                ack_data  = 16'($urandom);
            end
            MemListo   = (strobe_cnt == ack_after);
            MemDatoEnt = MemListo ? ack_data : 16'($urandom);
            strobe_cnt++;
        end else begin
            // Acks outside an access must be ignored by the DUT.
            strobe_cnt = 0;
            MemListo   = 1'($urandom);
            MemDatoEnt = 16'($urandom);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clr();
        n_leer = 0; n_escr = 0; n_listo = 0; n_error = 0;
    endtask

    task automatic esperar_libre();
        int n = 0;
        while (Ocupado && n < 40) begin
            @(negedge Reloj);
            n++;
        end
        chk("limite_espera_tb", Ocupado, 1'b0);
    endtask

    // Call at a negedge with the DUT idle.
    task automatic acceso(input bit w, input logic [15:0] dir, input logic [15:0] dat,
                          input int ack, input logic [15:0] adat);
        ack_after = ack;
        ack_data  = adat;
        Solicitud = 1'b1; Escribir = w; Direccion = dir; DatoEscritura = dat;
        @(negedge Reloj);
        Solicitud = 1'b0;
        Escribir = 1'($urandom);
        Direccion = 16'($urandom);
        DatoEscritura = 16'($urandom);
        esperar_libre();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reiniciar = 1'b0;
        repeat (3) @(negedge Reloj);
        Reiniciar = 1'b1;
        @(negedge Reloj);

        // 1. asynchronous reset in the middle of a read
        acceso(1'b0, 16'h0002, 16'h0, 0, 16'h1357);
        chk("t1_lectura_previa", DatoLectura, 16'h1357);
        ack_after = -1;
        Solicitud = 1'b1; Escribir = 1'b0; Direccion = 16'h0040;
        @(negedge Reloj);
        Solicitud = 1'b0;
        repeat (3) @(negedge Reloj);
        chk("t1_leer_en_vuelo", MemLeer, 1'b1);
        #2 Reiniciar = 1'b0;
        #1;
        chk("t1_reset_leer", MemLeer, 1'b0);
        chk("t1_reset_ocupado", Ocupado, 1'b0);
        chk("t1_reset_dato", DatoLectura, 16'h0000);
        @(negedge Reloj);
        Reiniciar = 1'b1;
        @(negedge Reloj);
        clr();
        acceso(1'b0, 16'h0041, 16'h0, 1, 16'h5A5A);
        chk("t1_tras_reset_dato", DatoLectura, 16'h5A5A);
        chk("t1_tras_reset_leer", n_leer, 2);
        chk("t1_tras_reset_listo", n_listo, 1);

        // 2. read, ack two cycles after the strobe rises
        clr();
        acceso(1'b0, 16'h0010, 16'h0, 2, 16'hBEEF);
        chk("t2_ciclos_leer", n_leer, 3);
        chk("t2_dato", DatoLectura, 16'hBEEF);
        chk("t2_listo", n_listo, 1);
        chk("t2_error", n_error, 0);

        // 3. zero-wait write
        clr();
        acceso(1'b1, 16'h00FF, 16'h1234, 0, 16'h0);
        chk("t3_ciclos_escr", n_escr, 1);
        chk("t3_dir", esc_dir, 16'h00FF);
        chk("t3_dato_sal", esc_dat, 16'h1234);
        chk("t3_dato_lect", DatoLectura, 16'hBEEF);
        chk("t3_listo", n_listo, 1);

        // 4. timeout
        clr();
        acceso(1'b0, 16'h0020, 16'h0, -1, 16'h0);
        chk("t4_ciclos_leer", n_leer, LIM);
        chk("t4_listo", n_listo, 1);
        chk("t4_error", n_error, 1);
        chk("t4_dato", DatoLectura, 16'hBEEF);

        // 5. ack on the timeout cycle
        clr();
        acceso(1'b0, 16'h0030, 16'h0, LIM - 1, 16'hCAFE);
        chk("t5_ciclos_leer", n_leer, LIM);
        chk("t5_error", n_error, 0);
        chk("t5_listo", n_listo, 1);
        chk("t5_dato", DatoLectura, 16'hCAFE);

        // 6. Solicitud held high: one access per idle visit
        clr();
        ack_after = 1;
        ack_data  = 16'hA5A5;
        Solicitud = 1'b1;
        for (int i = 0; i < 60; i++) begin
            Escribir      = 1'($urandom);
            Direccion     = 16'($urandom);
            DatoEscritura = 16'($urandom);
            @(negedge Reloj);
        end
        Solicitud = 1'b0;
        esperar_libre();
        chk("t6_accesos", n_listo, 15);
        chk("t6_ciclos_senal", n_leer + n_escr, 30);
        chk("t6_error", n_error, 0);

        // random phase, with one asynchronous reset in the middle
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            Solicitud     = ($urandom_range(0, 3) != 0);
            Escribir      = 1'($urandom);
            Direccion     = 16'($urandom);
            DatoEscritura = 16'($urandom);
            if (i == 200) begin
                #2 Reiniciar = 1'b0;
                @(negedge Reloj);
                Reiniciar = 1'b1;
            end
            @(negedge Reloj);
        end
        Solicitud = 1'b0;
        esperar_libre();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
